nvdla_rr_pkt_arb: RTL and testbench
===================================

# nvdla_rr_pkt_arb

Round-robin packet arbiter that shares one downstream valid/ready channel between `NUM_REQ` upstream requesters. Each grant lasts for a whole multi-beat packet, delimited by `last`. The block sits in front of shared NVDLA datapath resources such as a single write port or CSB return path. A request OR-reduction drives the arbitration decision, and a registered grant holds the channel until the packet tail is accepted.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters; legal range 2..8.
- `DW`, 32: payload width per requester.
- `IW`, 3: width of `gnt_id`; must satisfy 2^IW >= `NUM_REQ`.

Ports:
- `nvdla_core_clk`  in  1: single clock; all logic on the rising edge.
- `nvdla_core_rst`  in  1: synchronous, active-high reset.
- `req_valid`  in  NUM_REQ: per-requester beat valid.
- `req_pd`  in  NUM_REQ*DW: payloads; requester i occupies bits [i*DW +: DW].
- `req_last`  in  NUM_REQ: marks the final beat of a packet.
- `req_ready`  out  NUM_REQ: per-requester beat accept.
- `out_valid`  out  1: downstream beat valid.
- `out_pd`  out  DW: downstream payload.
- `out_last`  out  1: downstream final-beat marker.
- `out_ready`  in  1: downstream accept.
- `gnt_id`  out  IW: index of the current owner; valid while `busy`=1.
- `busy`  out  1: channel locked to a requester.

## Operation
- State machine has two states, IDLE and LOCK. Registers: `state`, `gnt_id`, `ptr` (IW bits, the highest-priority index).
- **IDLE:**
  - `any_req` = OR-reduction of `req_valid`.
  - If `any_req`=1, the winner is the first asserted `req_valid` searching from `ptr` upward, wrapping modulo `NUM_REQ`.
  - Next cycle: `gnt_id` <= winner, `state` <= LOCK.
  - No beat is accepted in IDLE: all `req_ready`=0 and `out_valid`=0.
- **LOCK:**
  - `out_valid` = `req_valid[gnt_id]`, `out_pd` = `req_pd[gnt_id]`, `out_last` = `req_last[gnt_id]`.
  - `req_ready[gnt_id]` = `out_ready`; every other `req_ready` = 0.
  - A handshake occurs when `out_valid` & `out_ready`.
  - On a handshake with `out_last`=1: `state` <= IDLE and `ptr` <= (`gnt_id`+1) mod `NUM_REQ`.
- If the owner deasserts `req_valid` mid-packet, the lock holds and `out_valid`=0 until the owner resumes. The arbiter has no timeout.
- Other requesters are never starved: after the owner's packet ends, the owner has lowest priority.
- When `out_valid`=0, `out_pd` and `out_last` are don't-care. Implementation drives them from the `gnt_id` mux.
- Reset values:
  - State and registers: `state`=IDLE, `gnt_id`=0, `ptr`=0.
  - Outputs: `busy`=0, `out_valid`=0, all `req_ready`=0.
  - `out_pd` and `out_last` are don't-care while `out_valid`=0.
- Reset asserted mid-packet aborts the lock on the next edge. No beat is accepted in the reset cycle because all ready outputs are forced to 0 while `nvdla_core_rst`=1.

## Timing
- Request to first `out_valid`: 1 cycle, because the grant is registered in IDLE.
- In LOCK: `out_valid`, `out_pd` and `req_ready` are combinational from inputs (zero latency). There is no combinational path from `out_ready` to `out_valid`.
- Packet gap: exactly 1 IDLE cycle after each `last` handshake, for re-arbitration.
- Sustained throughput: packet of L beats with `out_ready`=1 occupies L+1 cycles.
- `busy` = (`state`==LOCK), registered.
- Simultaneous events:
  - New requests arriving during LOCK are ignored until IDLE.
  - A `last` handshake and a new `req_valid` from the same owner in the same cycle: the owner is re-arbitrated at lowest priority in the following IDLE cycle.

## Test plan
- **Single requester:** reset, then `req_valid`=0001 with a 3-beat packet and `out_ready`=1.
  - `busy` rises at cycle 1.
  - Beats appear at cycles 1-3 with `gnt_id`=0.
  - IDLE at cycle 4; `ptr`=1.
- **All four requesting:** 2-beat packets each, `out_ready`=1.
  - Grant order 0,1,2,3,0.
  - Exactly one IDLE bubble between packets.
  - `req_ready` is one-hot and only on the owner.
- **Backpressure:** `out_ready` toggles 0/1 every cycle during a 4-beat packet.
  - Payloads are received in order with no duplication or loss.
  - Packet completes after 8 LOCK cycles.
- **Owner stalls mid-packet:** owner drops `req_valid` for 5 cycles while requester 2 is valid.
  - `gnt_id` is unchanged and `out_valid`=0 during the stall.
  - Requester 2 is granted only after the owner's `last` handshake.
- **Wrap-around:** `ptr`=3 after a grant to 2; requesters 0 and 3 are both valid.
  - Grant goes to 3; the next grant goes to 0.
- **Reset mid-packet:** assert `nvdla_core_rst` during beat 2 of 4.
  - All `req_ready`=0 in the reset cycle.
  - Next cycle: `busy`=0, `gnt_id`=0, `ptr`=0.
  - A fresh request is granted by requester-0-first priority.

Source files
------------

// File: rtl/nvdla_rr_pkt_arb.sv
// Round-robin packet arbiter: one downstream valid/ready channel shared by
// NUM_REQ requesters, each grant held until the packet tail is accepted.
module nvdla_rr_pkt_arb #(
    parameter int NUM_REQ = 4,
    parameter int DW      = 32,
    parameter int IW      = 3
) (
    input  logic                    nvdla_core_clk,
    input  logic                    nvdla_core_rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*DW-1:0]   req_pd,
    input  logic [NUM_REQ-1:0]      req_last,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    out_valid,
    output logic [DW-1:0]           out_pd,
    output logic                    out_last,
    input  logic                    out_ready,
    output logic [IW-1:0]           gnt_id,
    output logic                    busy
);

    localparam logic [0:0]  ST_IDLE   = 1'b0;
    localparam logic [0:0]  ST_LOCK   = 1'b1;
    localparam logic [IW:0] NUM_REQ_W = (IW+1)'(NUM_REQ);
    localparam logic [IW-1:0] LAST_ID = IW'(NUM_REQ - 1);

    logic [0:0]             state_q, state_d;
    logic [IW-1:0]          gnt_id_q, gnt_id_d;
    logic [IW-1:0]          ptr_q, ptr_d;

    logic                   any_req;
    logic [2*NUM_REQ-1:0]   req_dbl;
    logic [NUM_REQ-1:0]     req_rot;
    logic                   hit;
    logic [IW-1:0]          win_off;
    logic [IW:0]            win_sum;
    logic [IW-1:0]          win_id;

    logic                   sel_valid;
    logic                   sel_last;
    logic [DW-1:0]          sel_pd;
    logic                   lock;
    logic                   hs;
    logic [IW-1:0]          ptr_next;

    assign any_req = |req_valid;

    // Rotate so that bit 0 is the highest-priority requester (ptr).
    assign req_dbl = {req_valid, req_valid};
    assign req_rot = NUM_REQ'(req_dbl >> ptr_q);

    always_comb begin
        hit     = 1'b0;
        win_off = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!hit && req_rot[k]) begin
                hit     = 1'b1;
                win_off = IW'(k);
            end
        end
    end

    assign win_sum = {1'b0, ptr_q} + {1'b0, win_off};
    assign win_id  = (win_sum >= NUM_REQ_W) ? IW'(win_sum - NUM_REQ_W)
                                            : IW'(win_sum);

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_pd    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_id_q == IW'(i)) begin
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
                sel_pd    = req_pd[i*DW +: DW];
            end
        end
    end

    // Reset gates every accept so no beat is lost in the reset cycle.
    assign lock      = (state_q == ST_LOCK) & ~nvdla_core_rst;
    assign out_valid = lock & sel_valid;
    assign out_pd    = sel_pd;
    assign out_last  = sel_last;
    assign hs        = out_valid & out_ready;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = lock & out_ready & (gnt_id_q == IW'(i));
        end
    end

    assign ptr_next = (gnt_id_q == LAST_ID) ? '0 : gnt_id_q + IW'(1);

    always_comb begin
        state_d  = state_q;
        gnt_id_d = gnt_id_q;
        ptr_d    = ptr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    gnt_id_d = win_id;
                    state_d  = ST_LOCK;
                end
            end
            ST_LOCK: begin
                if (hs && sel_last) begin
                    state_d = ST_IDLE;
                    ptr_d   = ptr_next;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            state_q  <= ST_IDLE;
            gnt_id_q <= '0;
            ptr_q    <= '0;
        end else begin
            state_q  <= state_d;
            gnt_id_q <= gnt_id_d;
            ptr_q    <= ptr_d;
        end
    end

    assign busy   = (state_q == ST_LOCK);
    assign gnt_id = gnt_id_q;

endmodule

// File: tb/tb_nvdla_rr_pkt_arb.sv
// Randomized bench for nvdla_rr_pkt_arb against a packet-level
// round-robin reference model.
module tb_nvdla_rr_pkt_arb;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int IW = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N*DW-1:0]   req_pd;
    logic [N-1:0]      req_last;
    logic [N-1:0]      req_ready;
    logic              out_valid;
    logic [DW-1:0]     out_pd;
    logic              out_last;
    logic              out_ready;
    logic [IW-1:0]     gnt_id;
    logic              busy;

    always #5 clk = ~clk;

    nvdla_rr_pkt_arb #(
        .NUM_REQ (N),
        .DW      (DW),
        .IW      (IW)
    ) dut (
        .nvdla_core_clk (clk),
        .nvdla_core_rst (rst),
        .req_valid      (req_valid),
        .req_pd         (req_pd),
        .req_last       (req_last),
        .req_ready      (req_ready),
        .out_valid      (out_valid),
        .out_pd         (out_pd),
        .out_last       (out_last),
        .out_ready      (out_ready),
        .gnt_id         (gnt_id),
        .busy           (busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Per-requester packet source: current packet length, beat position,
    // payload base (beat payload = base + position).
    int          pkt_len  [N];
    int          pkt_pos  [N];
    logic [31:0] pkt_base [N];

    // Reference model: channel locked?, owner register, priority pointer.
    int m_lock = 0;
    int m_own  = 0;
    int m_ptr  = 0;
    int n_pkts = 0;

    task automatic new_pkt(input int i);
        pkt_len[i]  = $urandom_range(4, 1);
        pkt_pos[i]  = 0;
        pkt_base[i] = {8'(i), 24'($urandom)};
    endtask

    task automatic step(input logic r, input int vp, input int rp);
        logic         ev;
        logic [N-1:0] er;
        logic [31:0]  epd;
        logic         elast;
        int           c;
        @(negedge clk);
        rst = r;
        for (int i = 0; i < N; i++) begin
            req_valid[i]         = ($urandom_range(99) < vp);
            req_pd[i*DW +: DW]   = pkt_base[i] + 32'(pkt_pos[i]);
            req_last[i]          = (pkt_pos[i] == pkt_len[i] - 1);
        end
        out_ready = ($urandom_range(99) < rp);
        #1;
        ev    = (m_lock != 0) && !r && req_valid[m_own];
        er    = ((m_lock != 0) && !r && out_ready) ? (N'(1) << m_own) : '0;
        epd   = pkt_base[m_own] + 32'(pkt_pos[m_own]);
        elast = (pkt_pos[m_own] == pkt_len[m_own] - 1);
        chk("busy", busy, m_lock != 0);
        chk("gnt_id", gnt_id, m_own);
        chk("out_valid", out_valid, ev);
        chk("req_ready", req_ready, er);
        if (ev) begin
            chk("out_pd", out_pd, epd);
            chk("out_last", out_last, elast);
        end
        @(posedge clk);
        if (r) begin
            m_lock = 0;
            m_own  = 0;
            m_ptr  = 0;
        end else if (m_lock == 0) begin
            for (int k = 0; k < N; k++) begin
                c = (m_ptr + k) % N;
                if (req_valid[c]) begin
                    m_lock = 1;
                    m_own  = c;
                    break;
                end
            end
        end else if (ev && out_ready) begin
            pkt_pos[m_own]++;
            if (elast) begin
                n_pkts++;
                new_pkt(m_own);
                m_lock = 0;
                m_ptr  = (m_own + 1) % N;
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_pd    = '0;
        req_last  = '0;
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) new_pkt(i);
        @(posedge clk);
        step(1'b1, 50, 50);
        step(1'b1, 90, 90);
        for (int n = 0; n < 400; n++) step(1'b0, 95, 100);
        for (int n = 0; n < 400; n++) step(1'b0, 70, 50);
        for (int n = 0; n < 400; n++) step(1'b0, 25, 80);
        for (int n = 0; n < 600; n++)
            step(($urandom_range(59) == 0), 60 + 30 * (n % 2), 60);
        for (int n = 0; n < 20; n++) step(1'b0, 100, 100);
        step(1'b1, 100, 100);
        for (int n = 0; n < 20; n++) step(1'b0, 100, 100);
        chk("pkts_done", 64'(n_pkts > 50), 64'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
